uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter (8N1, LSB first) that serialises a byte onto a single dedicated output pin of the tile top level. It is the outbound counterpart to the pin-sampling input path: user logic hands over a byte with a valid/ready handshake and the block drives the framed serial stream. The block is fully synchronous to the tile clock, and the bit period is a fixed integer number of clock cycles.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
- clk  input  1  tile clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_data  input  8  byte to send; sampled only on the accept edge.
- tx_valid  input  1  byte on tx_data is offered.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  a frame is in progress (state is not IDLE).

## Operation
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, tx=1, tx_ready=1, busy=0, state=IDLE, and the counters are cleared.
- Accept: an accept occurs on a rising edge where tx_valid=1 and tx_ready=1. tx_ready is a combinational decode of state==IDLE.
- States: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On accept, load the shift register with tx_data, set bit_cnt=0 and baud_cnt=CLKS_PER_BIT-1, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]. When baud_cnt reaches 0, shift right by 1 and increment bit_cnt. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- baud_cnt counts down from CLKS_PER_BIT-1 to 0 and reloads on each bit boundary. Its width is clog2(CLKS_PER_BIT). bit_cnt is 3 bits.
- tx is a registered output, so no combinational glitches reach the pad.
- Input changes are ignored outside the accept edge:
  - tx_data changes after accept do not affect the frame in flight.
  - tx_valid asserted while busy is ignored and does not queue a byte.
- Reset asserted mid-frame aborts the frame. tx returns to 1 asynchronously. No partial byte is resumed after reset releases.

## Timing
- Accept at edge E: tx falls to 0 after edge E, and busy=1 and tx_ready=0 from the same point.
- Start bit: cycles E+1 .. E+CLKS_PER_BIT.
- Data bit n (n=0..7): cycles E+(n+1)·CLKS_PER_BIT+1 .. E+(n+2)·CLKS_PER_BIT.
- Stop bit ends at edge E+10·CLKS_PER_BIT. After that edge, busy=0 and tx_ready=1.
- Back-to-back traffic with tx_valid held at 1 gives a frame period of exactly 10·CLKS_PER_BIT+1 cycles. This includes one idle-high cycle between the stop bit and the next start bit.
- Accept-to-first-edge-of-start-bit latency is 1 cycle. There is no other pipeline latency.

## Test plan
- Reset values: with rst_n=0 and CLKS_PER_BIT=4, expect tx=1, tx_ready=1, busy=0. Assert rst_n=0 asynchronously mid-cycle during a frame; tx must go to 1 before the next clock edge.
- Single byte: CLKS_PER_BIT=4, send 0x55.
  - Sampling tx every 4 cycles from E+1 gives 0,1,0,1,0,1,0,1,0,1 (start, LSB..MSB, stop).
  - busy is high for exactly 40 cycles.
- LSB order and data capture: send 0x01, then flip tx_data to 0xFF one cycle after accept. Expected bits are 0 (start), then 1,0,0,0,0,0,0,0, then 1 (stop).
- Back-to-back: hold tx_valid=1 with 0xA5 then 0x3C. The second start bit begins exactly 41 cycles after the first. The decoded bytes are 0xA5 and 0x3C.
- Ignored valid while busy: pulse tx_valid with 0xFF during a frame of 0x00. Only the 0x00 frame is sent, and tx stays 1 after its stop bit.
- Mid-frame reset: reset during data bit 3 of 0x0F. After release, tx stays 1 and tx_ready=1. A new byte 0x81 is then sent correctly.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 LSB-first UART transmitter with valid/ready byte input
// Frame: one start bit (0), eight data bits, one stop bit (1); each bit lasts CLKS_PER_BIT clocks.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic          tx_q, tx_d;
    logic          baud_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign baud_done = (baud_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    bit_cnt_d  = '0;
                    baud_cnt_d = BAUD_MAX;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d    = DATA;
                    baud_cnt_d = BAUD_MAX;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    baud_cnt_d = BAUD_MAX;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is decoded from the next state so the pad sees a flop output with no extra latency.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        tx_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard testbench for uart_tx with a serial-line decoding monitor
module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    longint     starts[$];

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: decode frames from the line, sampling each bit one cycle into its period.
    logic [9:0] mon_bits;
    bit         mon_abort;
    int         mon_i;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                starts.push_back(longint'($time));
                mon_bits  = '0;
                mon_abort = 1'b0;
                mon_i     = 0;
                while (mon_i < 9 * C + 1 && !mon_abort) begin
                    @(negedge clk);
                    mon_i++;
                    if (rst_n !== 1'b1) mon_abort = 1'b1;
                    else if ((mon_i - 1) % C == 0) mon_bits[(mon_i - 1) / C] = tx;
                end
                if (!mon_abort) begin
                    chk("start_bit", 32'(mon_bits[0]), 32'd0);
                    chk("stop_bit", 32'(mon_bits[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_bits[8:1]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("frame_byte", 32'(mon_bits[8:1]), 32'(mon_exp));
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit expect_it);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        if (expect_it) exp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_high(input string name, input int cycles);
        int ones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx === 1'b1 && tx_ready === 1'b1) ones++;
        end
        chk(name, 32'(ones), 32'(cycles));
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Async reset during the start bit: line must return high before the next edge.
        send(8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check_idle_high("post_async_rst_idle", 10);

        // 0x55: accept timing and busy duration.
        send(8'h55, 1'b1);
        @(negedge clk);
        chk("accept_tx_low", 32'(tx), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(tx_ready), 32'd0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'(10 * C));
        drain();

        // 0x01 with tx_data flipped after accept.
        send(8'h01, 1'b1);
        @(negedge clk);
        tx_data = 8'hFF;
        drain();

        // Back-to-back with tx_valid held high.
        starts.delete();
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        tx_data = 8'h3C;
        exp_q.push_back(8'h3C);
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        drain();
        chk("b2b_frames", 32'(starts.size()), 32'd2);
        if (starts.size() >= 2) chk("b2b_period", 32'(starts[1] - starts[0]), 32'((10 * C + 1) * 10));

        // tx_valid pulsed while busy is ignored.
        send(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        drain();
        check_idle_high("ignored_valid_idle", 20);

        // Reset during data bit 3 of 0x0F, then a clean 0x81.
        send(8'h0F, 1'b0);
        repeat (17) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check_idle_high("post_mid_rst_idle", 20);
        send(8'h81, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
